// File: rtl/apb_master_pkg.sv
// Shared types and constants for the APB master that talks to the timer peripheral.
// The FSM state encoding and the timer register map used by drivers and benches.
package apb_master_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } state_t;

   // Timer register map (byte addresses within the 12-bit APB window)
   localparam logic [11:0] TCR   = 12'h000;
   localparam logic [11:0] TDR0  = 12'h004;
   localparam logic [11:0] TDR1  = 12'h008;
   localparam logic [11:0] TCMP0 = 12'h00C;
   localparam logic [11:0] TCMP1 = 12'h010;
   localparam logic [11:0] TIER  = 12'h014;
   localparam logic [11:0] TISR  = 12'h018;
   localparam logic [11:0] THCSR = 12'h01C;

endpackage

// File: rtl/apb_master.sv
// APB3/APB4 initiator: one valid/ready command in, one APB transfer out, one response back.
// Define APB_MASTER_TIMEOUT_EN to abandon transfers after TIMEOUT_CYC wait states.
module apb_master
   import apb_master_pkg::*;
#(
   parameter int ADDR_W      = 12,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_wdata,
   input  logic [DATA_W/8-1:0] cmd_strb,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                psel,
   output logic                penable,
   output logic                pwrite,
   output logic [ADDR_W-1:0]   paddr,
   output logic [DATA_W-1:0]   pwdata,
   output logic [DATA_W/8-1:0] pstrb,
   input  logic                pready,
   input  logic [DATA_W-1:0]   prdata,
   input  logic                pslverr
);

   state_t state;

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] wait_cnt;
`endif

   // All APB and handshake outputs are registered so nothing toggles combinationally toward the slave.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= IDLE;
         cmd_ready <= 1'b1;
         psel      <= 1'b0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
         pstrb     <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
         wait_cnt  <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  paddr     <= cmd_addr;
                  pwrite    <= cmd_write;
                  pwdata    <= cmd_wdata;
                  pstrb     <= cmd_write ? cmd_strb : '0;
                  psel      <= 1'b1;
                  cmd_ready <= 1'b0;
                  state     <= SETUP;
               end
            end
            SETUP: begin
               penable <= 1'b1;
               state   <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
               wait_cnt <= '0;
`endif
            end
            ACCESS: begin
               if (pready) begin
                  rsp_rdata <= pwrite ? '0 : prdata;
                  rsp_err   <= pslverr;
                  psel      <= 1'b0;
                  penable   <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else begin
`ifdef APB_MASTER_TIMEOUT_EN
                  // The limit-th wait cycle ends the transfer; pready on that cycle still wins above.
                  if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                     rsp_rdata <= '0;
                     rsp_err   <= 1'b1;
                     psel      <= 1'b0;
                     penable   <= 1'b0;
                     rsp_valid <= 1'b1;
                     state     <= RESP;
                  end else begin
                     wait_cnt <= wait_cnt + CNT_W'(1);
                  end
`endif
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master with a small timer-like APB slave model and a response scoreboard.
// Exercises the APB_MASTER_TIMEOUT_EN path when that macro is defined for the build.
module tb_apb_master;
   import apb_master_pkg::*;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [11:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_strb;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic        psel, penable, pwrite, pready, pslverr;
   logic [11:0] paddr;
   logic [31:0] pwdata, prdata;
   logic [3:0]  pstrb;

   typedef struct {
      logic        write;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          waits;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   rsp_t sb[$];
   vec_t vec[9];
   int checks = 0;
   int failures = 0;

   always #5 sys_clk = ~sys_clk;

   apb_master dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr)
   );

   // Timer-like slave: word registers, byte strobes, divider values above 8 in TCR rejected.
   logic [31:0] mem [0:7];
   int slave_waits = 0;
   int wait_left = 0;
   bit stuck = 1'b0;

   assign pready  = psel && penable && (wait_left == 0) && !stuck;
   assign prdata  = (psel && penable) ? mem[paddr[4:2]] : 32'h0;
   assign pslverr = psel && penable && pwrite && (paddr == TCR) && pstrb[1] && (pwdata[11:8] > 4'h8);

   always @(posedge sys_clk) begin
      if (psel && !penable)
         wait_left <= slave_waits;
      else if (psel && penable && !pready)
         wait_left <= wait_left - 1;
      if (psel && penable && pready && pwrite && !pslverr)
         for (int b = 0; b < 4; b++)
            if (pstrb[b]) mem[paddr[4:2]][8*b +: 8] <= pwdata[8*b +: 8];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply_stimulus(input logic w, input logic [11:0] a, input logic [31:0] d,
                                 input logic [3:0] s);
      check("cmd_ready_before", 32'(cmd_ready), 32'd1);
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      cmd_strb  = s;
      cmd_valid = 1'b1;
      @(posedge sys_clk); #1;
      cmd_valid = 1'b0;
      check("setup_psel", 32'(psel), 32'd1);
      check("setup_penable", 32'(penable), 32'd0);
      check("setup_cmd_ready", 32'(cmd_ready), 32'd0);
      check("setup_paddr", 32'(paddr), 32'(a));
      check("setup_pwrite", 32'(pwrite), 32'(w));
      check("setup_pstrb", 32'(pstrb), w ? 32'(s) : 32'd0);
      check("setup_pwdata", pwdata, d);
   endtask

   task automatic check_output(input int exp_lat);
      int          lat;
      bit          hold_ok;
      logic [11:0] a0;
      logic [31:0] d0;
      logic [3:0]  s0;
      rsp_t        e;
      lat = 0;
      hold_ok = 1'b1;
      a0 = paddr;
      d0 = pwdata;
      s0 = pstrb;
      do begin
         @(posedge sys_clk); #1;
         lat++;
         if (!rsp_valid && !(psel && penable && paddr == a0 && pwdata == d0 && pstrb == s0))
            hold_ok = 1'b0;
      end while (!rsp_valid && lat < 300);
      check("access_hold", 32'(hold_ok), 32'd1);
      check("rsp_latency", 32'(lat), 32'(exp_lat));
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL scoreboard_empty: got 0 entries expected 1");
      end else begin
         e = sb.pop_front();
         check("rsp_rdata", rsp_rdata, e.rdata);
         check("rsp_err", 32'(rsp_err), 32'(e.err));
      end
      check("resp_psel", 32'(psel), 32'd0);
      check("resp_penable", 32'(penable), 32'd0);
      if (rsp_ready) begin
         @(posedge sys_clk); #1;
         check("post_rsp_valid", 32'(rsp_valid), 32'd0);
         check("post_cmd_ready", 32'(cmd_ready), 32'd1);
      end
   endtask

   task automatic run_cmd(input vec_t v);
      slave_waits = v.waits;
      sb.push_back('{v.exp_rdata, v.exp_err});
      apply_stimulus(v.write, v.addr, v.wdata, v.strb);
      check_output(2 + v.waits);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) mem[i] = 32'h0;
      mem[TDR0[4:2]]  = 32'h1234_5678;
      mem[TCMP0[4:2]] = 32'hFFFF_FFFF;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
      rsp_ready = 1'b1;

      vec[0] = '{1'b1, TCR,   32'h0000_0101, 4'hF, 0, 32'h0,         1'b0};
      vec[1] = '{1'b0, TCR,   32'h0,         4'hF, 1, 32'h0000_0101, 1'b0};
      vec[2] = '{1'b0, TCMP0, 32'h0,         4'hF, 3, 32'hFFFF_FFFF, 1'b0};
      vec[3] = '{1'b1, TCR,   32'h0000_0000, 4'h1, 0, 32'h0,         1'b0};
      vec[4] = '{1'b1, TCR,   32'h0000_0900, 4'h2, 0, 32'h0,         1'b1};
      vec[5] = '{1'b0, TCR,   32'h0,         4'h0, 2, 32'h0000_0100, 1'b0};
      vec[6] = '{1'b1, TCMP1, 32'hAABB_CCDD, 4'h5, 1, 32'h0,         1'b0};
      vec[7] = '{1'b0, TCMP1, 32'h0,         4'hF, 0, 32'h00BB_00DD, 1'b0};
      vec[8] = '{1'b1, TISR,  32'hDEAD_BEEF, 4'h0, 0, 32'h0,         1'b0};

      repeat (2) @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b1;
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_psel", 32'(psel), 32'd0);
      check("rst_penable", 32'(penable), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_paddr", 32'(paddr), 32'd0);
      check("rst_pwdata", pwdata, 32'd0);
      check("rst_pstrb", 32'(pstrb), 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      @(posedge sys_clk); #1;

      foreach (vec[i]) run_cmd(vec[i]);
      run_cmd('{1'b0, TISR, 32'h0, 4'hF, 0, 32'h0, 1'b0});

      // Response back-pressure with another command waiting behind it
      rsp_ready = 1'b0;
      slave_waits = 0;
      sb.push_back('{32'h1234_5678, 1'b0});
      apply_stimulus(1'b0, TDR0, 32'h0, 4'hF);
      check_output(2);
      cmd_write = 1'b1; cmd_addr = TIER; cmd_wdata = 32'h1; cmd_strb = 4'hF;
      cmd_valid = 1'b1;
      repeat (5) begin
         @(posedge sys_clk); #1;
         check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         check("bp_rsp_rdata", rsp_rdata, 32'h1234_5678);
         check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
         check("bp_psel", 32'(psel), 32'd0);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge sys_clk); #1;
      check("bp_release_rsp_valid", 32'(rsp_valid), 32'd0);
      check("bp_release_cmd_ready", 32'(cmd_ready), 32'd1);

      // Reset in the middle of a stalled ACCESS drops the transfer
      stuck = 1'b1;
      apply_stimulus(1'b0, TCR, 32'h0, 4'h0);
      @(posedge sys_clk); #1;
      check("mid_access_penable", 32'(penable), 32'd1);
      @(posedge sys_clk); #2;
      sys_rst_n = 1'b0;
      #1;
      check("midrst_psel", 32'(psel), 32'd0);
      check("midrst_penable", 32'(penable), 32'd0);
      check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
      @(posedge sys_clk); #1;
      sys_rst_n = 1'b1;
      stuck = 1'b0;
      @(posedge sys_clk); #1;
      run_cmd('{1'b1, TIER, 32'h0000_0007, 4'hF, 1, 32'h0, 1'b0});
      run_cmd('{1'b0, TIER, 32'h0,         4'hF, 0, 32'h7, 1'b0});

`ifdef APB_MASTER_TIMEOUT_EN
      // 16 wait cycles after entering ACCESS, no pready cycle: 17 edges after acceptance
      stuck = 1'b1;
      sb.push_back('{32'h0, 1'b1});
      apply_stimulus(1'b0, TDR0, 32'h0, 4'hF);
      check_output(17);
      stuck = 1'b0;
      run_cmd('{1'b0, TDR0, 32'h0, 4'hF, 0, 32'h1234_5678, 1'b0});
`else
      begin
         bit seen;
         seen = 1'b0;
         stuck = 1'b1;
         apply_stimulus(1'b0, TDR0, 32'h0, 4'hF);
         repeat (100) begin
            @(posedge sys_clk); #1;
            if (rsp_valid) seen = 1'b1;
         end
         check("no_timeout_rsp", 32'(seen), 32'd0);
         check("no_timeout_psel", 32'(psel), 32'd1);
         sys_rst_n = 1'b0;
         @(posedge sys_clk); #1;
         sys_rst_n = 1'b1;
         stuck = 1'b0;
         @(posedge sys_clk); #1;
         run_cmd('{1'b0, TDR0, 32'h0, 4'hF, 0, 32'h1234_5678, 1'b0});
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB initiator that turns a simple valid/ready command stream into APB3/APB4 transfers toward the timer's APB slave (12-bit address, 32-bit data).
- Returns read data and the slave error for each transfer on a valid/ready response channel.
- Sits between the system/debug command source and the timer peripheral. Handles one outstanding transfer at a time.

Parameters:
- ADDR_W, 12, APB address width.
- DATA_W, 32, APB data width (multiple of 8).
- TIMEOUT_CYC, 16, wait-state limit; used only with APB_MASTER_TIMEOUT_EN.

Ports:
- sys_clk  in  1  clock
- sys_rst_n  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- cmd_strb  in  DATA_W/8  byte strobes (writes)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  read data (0 for writes)
- rsp_err  out  1  slave error (or timeout)
- psel, penable, pwrite  out  1  APB control
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- pstrb  out  DATA_W/8  APB strobes
- pready  in  1  slave ready
- prdata  in  DATA_W  slave read data
- pslverr  in  1  slave error

Behaviour:
- FSM states: IDLE, SETUP, ACCESS, RESP.
- Reset: state=IDLE. All outputs 0 except cmd_ready=1; paddr, pwdata, pstrb, rsp_rdata are all 0.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch cmd_write/addr/wdata/strb into paddr/pwrite/pwdata/pstrb and go to SETUP.
  - pstrb forced to 0 for reads.
- SETUP: psel=1, penable=0, cmd_ready=0. Always moves to ACCESS the next cycle.
- ACCESS:
  - psel=1, penable=1.
  - paddr/pwrite/pwdata/pstrb are held stable.
  - Each cycle with pready=0 is a wait state; stay in ACCESS.
  - On pready=1:
    - capture rsp_rdata = pwrite ? 0 : prdata;
    - capture rsp_err = pslverr;
    - go to RESP.
- RESP:
  - psel=0, penable=0, rsp_valid=1.
  - rsp_rdata and rsp_err are held until rsp_ready=1, then go to IDLE.
  - rsp_valid and rsp_ready high together → next state IDLE.
- Latency: command accepted at edge N → SETUP in cycle N+1 → ACCESS in N+2. With zero wait states, rsp_valid=1 in N+3. Each wait state adds one cycle.
- Minimum command-to-command spacing is 4 cycles (no pipelining; cmd_ready is low from SETUP through RESP).
- paddr/pwdata/pstrb keep their last values in IDLE. They are don't-care to the slave, but the bench checks they do not glitch while psel=1.
- pslverr is sampled only in ACCESS with pready=1. prdata is likewise sampled only then.
- The block does not check strobe or address legality; the slave decides.
- Reset asserted mid-transfer: immediately psel=penable=0, rsp_valid=0, state=IDLE. The pending command is dropped with no response.

Optional Feature:
- APB_MASTER_TIMEOUT_EN
- Defined:
  - A wait counter clears on entry to ACCESS and increments on each pready=0 cycle.
  - When it reaches TIMEOUT_CYC, the transfer is abandoned: go to RESP with rsp_err=1 and rsp_rdata=0, and deassert psel/penable.
  - pready=1 in the same cycle as the limit is a normal completion (pready wins).
- Undefined: no counter; the master waits indefinitely for pready.

Decomposition:
- Shared package apb_master_pkg holds:
  - the FSM state enum (IDLE, SETUP, ACCESS, RESP);
  - timer register address constants TCR=0x000, TDR0=0x004, TDR1=0x008, TCMP0=0x00C, TCMP1=0x010, TIER=0x014, TISR=0x018, THCSR=0x01C, for use by benches and drivers.
- No sub-module is needed. The timeout counter is a few lines inside apb_master.

Test Plan:
- Write TCR: addr 0x000, wdata 0x0000_0101, strb 0xF, pready tied high → psel=1 in N+1, penable=1 in N+2, rsp_valid in N+3 with rsp_err=0 and rsp_rdata=0. The timer then reads back 0x0000_0101.
- Read TCMP0 after reset, slave holds pready low for 3 cycles → rsp_valid in N+6, rsp_rdata=0xFFFF_FFFF. paddr=0x00C stable throughout ACCESS.
- Write TCR div_val=0x9 (wdata 0x0000_0900, strb 0x2) → pslverr=1 with pready, rsp_err=1. Next read of TCR returns 0x0000_0100.
- rsp_ready held low for 5 cycles after a TDR0 read → rsp_valid and rsp_rdata stable, cmd_ready=0, no new psel while cmd_valid=1 is pending. Response clears one cycle after rsp_ready=1.
- Reset asserted while in ACCESS with pready=0 → psel, penable, and rsp_valid are 0 in the same cycle, cmd_ready=1. After release, a new TIER write completes normally.
- With APB_MASTER_TIMEOUT_EN defined and TIMEOUT_CYC=16, pready stuck low → rsp_valid after 16 wait cycles with rsp_err=1 and rsp_rdata=0. Without the macro, no response appears after 100 cycles.
